dbgapb_mst: RTL and testbench
=============================

Name: dbgapb_mst

Overview:
- APB initiator that drives the debug APB slave port from a host/JTAG-side command channel.
- Takes one high-level debug command (attach, resume, status, PC/GPR/CSR read/write, execute instruction) over a valid/ready handshake.
- Expands it into the fixed sequence of APB register accesses, waits on the slave's pready stretching, and returns read data and error on a response handshake.
- Sits between the debug transport and the core's debug APB slave.

Parameters:
- XLEN, 32, data width of GPR/CSR/PC values; only 32 or 64 are legal. 64 adds the _H register accesses.
- TIMEOUT, 1023, maximum ACCESS-phase wait cycles. Used only with DBGAPB_MST_TIMEOUT_EN.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  4  0 ATTACH, 1 RESUME, 2 STATUS, 3 PC_RD, 4 GPR_RD, 5 CSR_RD, 6 GPR_WR, 7 CSR_WR, 8 EXEC; 9-15 illegal.
- cmd_addr  in  12  GPR index [4:0] or CSR number.
- cmd_wdata  in  XLEN  write value; the instruction word in [31:0] for EXEC.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  XLEN  read result; 0 for write-type ops.
- rsp_err  out  1  pslverr seen, illegal op, or timeout.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  32  APB address.
- pstrb  out  4  always 4'hf on writes, 0 on reads.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pslverr  in  1  APB error.
- pready  in  1  APB ready.
- busy  out  1  high from command accept until the response handshake.

Behaviour:
- Reset: all outputs 0; cmd_ready=0 while in reset; dbg_en_done flag=0; FSM=IDLE.
- FSM states: IDLE, SETUP, ACCESS, STEP, RESP.
- IDLE: cmd_ready=1. On valid&ready:
  - latch op, addr and wdata;
  - step index=0;
  - if dbg_en_done=0, prepend step "write DBG_EN=1";
  - go to SETUP.
- SETUP (one cycle): psel=1, penable=0; paddr/pwrite/pwdata come from the current step. Go to ACCESS.
- ACCESS: psel=1, penable=1; hold all APB outputs until pready=1. On pready=1:
  - sample prdata into rdata[31:0] (RDATA_L step) or rdata[63:32] (RDATA_H step);
  - OR pslverr into err;
  - go to STEP.
- STEP: deassert psel/penable for one cycle. Increment the step index. If steps remain go to SETUP, else go to RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready. Then clear err, set dbg_en_done=1, go to IDLE.
- rsp_ready is ignored outside RESP. A command can be accepted no earlier than the cycle after the response handshake.
- Instruction word: inst = {4'b0, addr[11:0], 4'b0, code[11:0]}.
- Instruction codes: ATTACH 0x001, RESUME 0x002, INSTREG_WR 0x003, EXECUTE 0x004, STATUS_RD 0x005, PC_RD 0x006, GPR_RD 0x007, CSR_RD 0x008, GPR_WR 0x009, CSR_WR 0x00A.
- Register map (byte offset in paddr[11:0], upper bits 0): DBG_EN 0x000, INST 0x004, INST_WR 0x008, WDATA_L 0x00C, WDATA_H 0x010, WDATA_WR 0x014, RDATA_L 0x018, RDATA_H 0x01C.
- Step sequences ("W" = write, "R" = read, "INST<-x" = write INST with instruction x, "INST_WR" = write INST_WR=1):
  - ATTACH, RESUME: INST<-code; INST_WR.
  - STATUS, PC_RD, GPR_RD, CSR_RD: INST<-code; INST_WR; R RDATA_L; R RDATA_H (XLEN=64 only).
  - GPR_WR, CSR_WR: W WDATA_L; W WDATA_H (XLEN=64 only); W WDATA_WR=1; INST<-code; INST_WR.
  - EXEC: W WDATA_L=inst; W WDATA_WR=1; INST<-INSTREG_WR; INST_WR; INST<-EXECUTE; INST_WR.
- Illegal op: no APB traffic; go straight to RESP with rsp_err=1 and rsp_rdata=0.
- pslverr does not abort the sequence; err is sticky for the command.
- Reset mid-transfer: psel/penable drop asynchronously; the command is lost and no response is produced. The next command re-issues the DBG_EN write.

Optional Feature:
- Macro: DBGAPB_MST_TIMEOUT_EN.
- With it: a 10-bit wait counter runs in ACCESS. If it exceeds TIMEOUT with pready low:
  - drop psel/penable;
  - set err=1;
  - skip the remaining steps and go to RESP with rsp_rdata=0;
  - leave dbg_en_done=0.
- Without it: ACCESS waits for pready indefinitely and there is no counter logic.

Decomposition:
- Shared package dbgapb_pkg holds:
  - register offset localparams and instruction-code localparams (shared with the slave);
  - cmd_op enum;
  - step struct {wr, addr[11:0], data_sel} and the FSM state enum.
- One sub-module, dbgapb_mst_seq: a combinational step decoder. Inputs are op, step index, XLEN and dbg_en_done. Outputs are the step fields and a last flag.

Test Plan:
- First ATTACH after reset → APB writes 0x000=1, 0x004=0x001, 0x008=1 in that order, each with a one-cycle SETUP. Response has rsp_err=0. A second ATTACH omits the 0x000 write.
- GPR_RD addr=5, slave pready low 1 cycle on INST_WR, prdata=0xDEADBEEF on 0x018 → INST write 0x00050007, ACCESS stretched 1 cycle, rsp_rdata=0xDEADBEEF.
- XLEN=64, CSR_WR addr=0x300, wdata=0x11223344_55667788 → writes 0x00C=0x55667788, 0x010=0x11223344, 0x014=1, 0x004=0x0300000A, 0x008=1.
- EXEC wdata=0x00100073 → six writes as sequenced, including 0x004=0x003 then 0x004=0x004. busy stays high throughout; rsp_valid held until rsp_ready.
- pslverr=1 on the INST write of STATUS → remaining steps still issued, rsp_err=1. cmd_op=12 → no psel, immediate rsp_err=1.
- Reset asserted during ACCESS → psel=0 the same cycle. With DBGAPB_MST_TIMEOUT_EN and TIMEOUT=8, pready stuck low → abort after 8 cycles with rsp_err=1.

Source files
------------

// File: rtl/dbgapb_pkg.sv
// Shared definitions for the debug APB initiator and its slave.
// Holds register offsets, instruction codes, command opcodes, the step
// descriptor produced by the sequencer, FSM state encodings and small helpers.
package dbgapb_pkg;

   // Debug APB register byte offsets (paddr[11:0]).
   localparam logic [11:0] REG_DBG_EN   = 12'h000;
   localparam logic [11:0] REG_INST     = 12'h004;
   localparam logic [11:0] REG_INST_WR  = 12'h008;
   localparam logic [11:0] REG_WDATA_L  = 12'h00C;
   localparam logic [11:0] REG_WDATA_H  = 12'h010;
   localparam logic [11:0] REG_WDATA_WR = 12'h014;
   localparam logic [11:0] REG_RDATA_L  = 12'h018;
   localparam logic [11:0] REG_RDATA_H  = 12'h01C;

   // Debug instruction codes.
   localparam logic [11:0] CODE_ATTACH     = 12'h001;
   localparam logic [11:0] CODE_RESUME     = 12'h002;
   localparam logic [11:0] CODE_INSTREG_WR = 12'h003;
   localparam logic [11:0] CODE_EXECUTE    = 12'h004;
   localparam logic [11:0] CODE_STATUS_RD  = 12'h005;
   localparam logic [11:0] CODE_PC_RD      = 12'h006;
   localparam logic [11:0] CODE_GPR_RD     = 12'h007;
   localparam logic [11:0] CODE_CSR_RD     = 12'h008;
   localparam logic [11:0] CODE_GPR_WR     = 12'h009;
   localparam logic [11:0] CODE_CSR_WR     = 12'h00A;

   localparam int unsigned STEP_IDX_W = 4;

   typedef enum logic [3:0] {
      OP_ATTACH = 4'd0, OP_RESUME = 4'd1, OP_STATUS = 4'd2, OP_PC_RD  = 4'd3,
      OP_GPR_RD = 4'd4, OP_CSR_RD = 4'd5, OP_GPR_WR = 4'd6, OP_CSR_WR = 4'd7,
      OP_EXEC   = 4'd8
   } cmd_op_e;

   // Source of pwdata for a write step, or destination half for a read step.
   typedef enum logic [2:0] {
      DS_ONE, DS_INST_OP, DS_WDATA_L, DS_WDATA_H,
      DS_INST_INSTREG, DS_INST_EXEC, DS_RD_L, DS_RD_H
   } data_sel_e;

   typedef struct packed {
      logic      wr;
      logic [11:0] addr;
      data_sel_e data_sel;
   } step_t;

   // FSM state encodings.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_STEP   = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= 4'd8;
   endfunction

   function automatic logic [11:0] op_code(input logic [3:0] op);
      case (op)
         OP_ATTACH: return CODE_ATTACH;
         OP_RESUME: return CODE_RESUME;
         OP_STATUS: return CODE_STATUS_RD;
         OP_PC_RD:  return CODE_PC_RD;
         OP_GPR_RD: return CODE_GPR_RD;
         OP_CSR_RD: return CODE_CSR_RD;
         OP_GPR_WR: return CODE_GPR_WR;
         OP_CSR_WR: return CODE_CSR_WR;
         default:   return CODE_EXECUTE;
      endcase
   endfunction

   function automatic logic [31:0] mk_inst(input logic [11:0] addr, input logic [11:0] code);
      return {4'b0, addr, 4'b0, code};
   endfunction

   function automatic step_t mk_step(input logic wr, input logic [11:0] addr, input data_sel_e sel);
      step_t s;
      s.wr       = wr;
      s.addr     = addr;
      s.data_sel = sel;
      return s;
   endfunction

endpackage

// File: rtl/dbgapb_mst_seq.sv
// Combinational step decoder: maps (op, step index) to one APB access.
// Ports: op/idx/dbg_en_done in; step (wr, addr, data_sel) and last out.
// When dbg_en_done is low, index 0 is the DBG_EN=1 write and the op's own
// sequence is shifted up by one.
module dbgapb_mst_seq
   import dbgapb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [3:0]            op,
   input  logic [STEP_IDX_W-1:0] idx,
   input  logic                  dbg_en_done,
   output step_t                 step,
   output logic                  last
);

   localparam bit WIDE = (XLEN == 64);

   logic [STEP_IDX_W-1:0] j;
   logic [STEP_IDX_W-1:0] k;

   always_comb begin
      step = mk_step(1'b1, REG_INST_WR, DS_ONE);
      last = 1'b0;
      j    = dbg_en_done ? idx : idx - STEP_IDX_W'(1);
      // Narrow data path has no WDATA_H step; skip over it.
      k    = (!WIDE && j >= STEP_IDX_W'(1)) ? j + STEP_IDX_W'(1) : j;
      if (!dbg_en_done && idx == '0) begin
         step = mk_step(1'b1, REG_DBG_EN, DS_ONE);
      end else begin
         case (op)
            OP_ATTACH, OP_RESUME: begin
               if (j == STEP_IDX_W'(0)) step = mk_step(1'b1, REG_INST, DS_INST_OP);
               else begin step = mk_step(1'b1, REG_INST_WR, DS_ONE); last = 1'b1; end
            end
            OP_STATUS, OP_PC_RD, OP_GPR_RD, OP_CSR_RD: begin
               case (j)
                  STEP_IDX_W'(0): step = mk_step(1'b1, REG_INST, DS_INST_OP);
                  STEP_IDX_W'(1): step = mk_step(1'b1, REG_INST_WR, DS_ONE);
                  STEP_IDX_W'(2): begin step = mk_step(1'b0, REG_RDATA_L, DS_RD_L); last = !WIDE; end
                  default:        begin step = mk_step(1'b0, REG_RDATA_H, DS_RD_H); last = 1'b1; end
               endcase
            end
            OP_GPR_WR, OP_CSR_WR: begin
               case (k)
                  STEP_IDX_W'(0): step = mk_step(1'b1, REG_WDATA_L, DS_WDATA_L);
                  STEP_IDX_W'(1): step = mk_step(1'b1, REG_WDATA_H, DS_WDATA_H);
                  STEP_IDX_W'(2): step = mk_step(1'b1, REG_WDATA_WR, DS_ONE);
                  STEP_IDX_W'(3): step = mk_step(1'b1, REG_INST, DS_INST_OP);
                  default:        begin step = mk_step(1'b1, REG_INST_WR, DS_ONE); last = 1'b1; end
               endcase
            end
            OP_EXEC: begin
               case (j)
                  STEP_IDX_W'(0): step = mk_step(1'b1, REG_WDATA_L, DS_WDATA_L);
                  STEP_IDX_W'(1): step = mk_step(1'b1, REG_WDATA_WR, DS_ONE);
                  STEP_IDX_W'(2): step = mk_step(1'b1, REG_INST, DS_INST_INSTREG);
                  STEP_IDX_W'(3): step = mk_step(1'b1, REG_INST_WR, DS_ONE);
                  STEP_IDX_W'(4): step = mk_step(1'b1, REG_INST, DS_INST_EXEC);
                  default:        begin step = mk_step(1'b1, REG_INST_WR, DS_ONE); last = 1'b1; end
               endcase
            end
            default: last = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dbgapb_mst.sv
// Debug APB initiator: expands one host debug command into a fixed sequence
// of APB register accesses and returns read data / error on a response channel.
// Ports: pclk, preset (async, active-high); cmd_* command handshake;
// rsp_* response handshake; psel/penable/pwrite/paddr/pstrb/pwdata/prdata/
// pslverr/pready APB initiator; busy.
// Optional build macro DBGAPB_MST_TIMEOUT_EN: ACCESS wait limited to TIMEOUT
// cycles, after which the command is aborted with rsp_err=1.
module dbgapb_mst
   import dbgapb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic            pclk,
   input  logic            preset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [3:0]      cmd_op,
   input  logic [11:0]     cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            psel,
   output logic            penable,
   output logic            pwrite,
   output logic [31:0]     paddr,
   output logic [3:0]      pstrb,
   output logic [31:0]     pwdata,
   input  logic [31:0]     prdata,
   input  logic            pslverr,
   input  logic            pready,
   output logic            busy
);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("dbgapb_mst: XLEN must be 32 or 64");
   end
   if (TIMEOUT == 0 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("dbgapb_mst: TIMEOUT must be 1..1023");
   end

   logic [2:0]            state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [11:0]           addr_q, addr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STEP_IDX_W-1:0] idx_q, idx_d;
   logic                  last_q, last_d;
   data_sel_e             sel_q, sel_d;
   logic                  dbg_en_done_q, dbg_en_done_d, err_q, err_d;
   logic                  cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
   logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [31:0]           paddr_q, paddr_d, pwdata_q, pwdata_d;
   logic [3:0]            pstrb_q, pstrb_d;
`ifdef DBGAPB_MST_TIMEOUT_EN
   logic [9:0]            wait_q, wait_d;
   logic                  to_q, to_d;
`endif

   step_t       nxt_step;
   logic        nxt_last;
   logic        accept;
   logic        load, clr;
   logic [63:0] wdata_ext, rd_ext;
   logic [31:0] nxt_wdata;

   assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

   // Command latch and step index; feeds the decoder with the upcoming step.
   always_comb begin
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      if (accept) begin
         op_d    = cmd_op;
         addr_d  = cmd_addr;
         wdata_d = cmd_wdata;
         idx_d   = '0;
      end else if (state_q == ST_STEP && !last_q) begin
         idx_d = idx_q + STEP_IDX_W'(1);
      end
   end

   dbgapb_mst_seq #(.XLEN(XLEN)) u_seq (
      .op          (op_d),
      .idx         (idx_d),
      .dbg_en_done (dbg_en_done_q),
      .step        (nxt_step),
      .last        (nxt_last)
   );

   // Write data for the upcoming step.
   always_comb begin
      wdata_ext = 64'(wdata_d);
      case (nxt_step.data_sel)
         DS_ONE:          nxt_wdata = 32'd1;
         DS_INST_OP:      nxt_wdata = mk_inst(addr_d, op_code(op_d));
         DS_WDATA_L:      nxt_wdata = wdata_ext[31:0];
         DS_WDATA_H:      nxt_wdata = wdata_ext[63:32];
         DS_INST_INSTREG: nxt_wdata = mk_inst(12'h000, CODE_INSTREG_WR);
         DS_INST_EXEC:    nxt_wdata = mk_inst(12'h000, CODE_EXECUTE);
         default:         nxt_wdata = 32'd0;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      rdata_d       = rdata_q;
      last_d        = last_q;
      sel_d         = sel_q;
      dbg_en_done_d = dbg_en_done_q;
      err_d         = err_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      load          = 1'b0;
      clr           = 1'b0;
      rd_ext        = 64'(rdata_q);
`ifdef DBGAPB_MST_TIMEOUT_EN
      wait_d        = wait_q;
      to_d          = to_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rdata_d = '0;
               err_d   = 1'b0;
`ifdef DBGAPB_MST_TIMEOUT_EN
               to_d    = 1'b0;
`endif
               if (op_legal(cmd_op)) begin
                  load    = 1'b1;
                  state_d = ST_SETUP;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
`ifdef DBGAPB_MST_TIMEOUT_EN
            wait_d    = '0;
`endif
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               if (!pwrite_q) begin
                  if (sel_q == DS_RD_L) rd_ext[31:0]  = prdata;
                  if (sel_q == DS_RD_H) rd_ext[63:32] = prdata;
                  rdata_d = XLEN'(rd_ext);
               end
               err_d   = err_q | pslverr;
               clr     = 1'b1;
               state_d = ST_STEP;
            end
`ifdef DBGAPB_MST_TIMEOUT_EN
            else if (wait_q >= 10'(TIMEOUT - 1)) begin
               // Slave never answered: abandon the whole command.
               clr     = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
               to_d    = 1'b1;
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q + 10'd1;
            end
`endif
         end
         ST_STEP: begin
            if (last_q) begin
               state_d = ST_RESP;
            end else begin
               load    = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               err_d         = 1'b0;
`ifdef DBGAPB_MST_TIMEOUT_EN
               dbg_en_done_d = dbg_en_done_q | ~to_q;
`else
               dbg_en_done_d = 1'b1;
`endif
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clr) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         paddr_d   = '0;
         pwdata_d  = '0;
         pstrb_d   = '0;
      end
      if (load) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = nxt_step.wr;
         paddr_d   = 32'(nxt_step.addr);
         pwdata_d  = nxt_step.wr ? nxt_wdata : 32'd0;
         pstrb_d   = nxt_step.wr ? 4'hf : 4'h0;
         sel_d     = nxt_step.data_sel;
         last_d    = nxt_last;
      end

      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         idx_q         <= '0;
         last_q        <= 1'b0;
         sel_q         <= DS_ONE;
         dbg_en_done_q <= 1'b0;
         err_q         <= 1'b0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
`ifdef DBGAPB_MST_TIMEOUT_EN
         wait_q        <= '0;
         to_q          <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         sel_q         <= sel_d;
         dbg_en_done_q <= dbg_en_done_d;
         err_q         <= err_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         busy_q        <= busy_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
`ifdef DBGAPB_MST_TIMEOUT_EN
         wait_q        <= wait_d;
         to_q          <= to_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = busy_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_dbgapb_mst.sv
// Directed self-checking bench for dbgapb_mst (XLEN=64, TIMEOUT=8) with a
// small APB slave model and a negedge transaction logger.
module tb_dbgapb_mst;

   localparam int unsigned XLEN = 64;
   localparam logic [3:0] OP_ATTACH = 4'd0, OP_STATUS = 4'd2, OP_PC_RD = 4'd3,
                          OP_GPR_RD = 4'd4, OP_CSR_WR = 4'd7, OP_EXEC = 4'd8;

   logic            pclk = 1'b0;
   logic            preset = 1'b1;
   logic            cmd_valid = 1'b0, cmd_ready;
   logic [3:0]      cmd_op = '0;
   logic [11:0]     cmd_addr = '0;
   logic [XLEN-1:0] cmd_wdata = '0;
   logic            rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [XLEN-1:0] rsp_rdata;
   logic            psel, penable, pwrite, pslverr, pready, busy;
   logic [31:0]     paddr, pwdata, prdata;
   logic [3:0]      pstrb;

   int errors = 0;
   int checks = 0;

   // Slave model controls.
   logic        stuck = 1'b0;
   logic [11:0] stall_addr = 12'hFFF;
   int          stall_n = 0;
   logic        err_en = 1'b0;
   logic [11:0] err_addr = 12'h000;
   logic [31:0] rd_l = '0, rd_h = '0;
   int          wait_cnt;

   // Transaction log.
   logic        log_wr   [16];
   logic [31:0] log_addr [16];
   logic [31:0] log_data [16];
   logic [3:0]  log_strb [16];
   int          log_acc  [16];
   int n_txn = 0, setup_cnt = 0, acc_total = 0, acc_cur = 0;
   int busy_low = 0, hold_bad = 0;

   dbgapb_mst #(.XLEN(XLEN), .TIMEOUT(8)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pstrb(pstrb),
      .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr), .pready(pready), .busy(busy)
   );

   always #5 pclk = ~pclk;

   assign pready  = psel && penable && !stuck && !(paddr[11:0] == stall_addr && wait_cnt < stall_n);
   assign prdata  = (paddr[11:0] == 12'h018) ? rd_l : (paddr[11:0] == 12'h01C) ? rd_h : 32'h0;
   assign pslverr = psel && penable && err_en && (paddr[11:0] == err_addr);

   always @(posedge pclk or posedge preset) begin
      if (preset) wait_cnt <= 0;
      else        wait_cnt <= (psel && penable && !pready) ? wait_cnt + 1 : 0;
   end

   always @(negedge pclk) begin
      if (!preset) begin
         if (psel && !penable) setup_cnt++;
         if (psel && penable) begin
            acc_total++;
            acc_cur++;
            if (pready) begin
               if (n_txn < 16) begin
                  log_wr[n_txn]   = pwrite;
                  log_addr[n_txn] = paddr;
                  log_data[n_txn] = pwdata;
                  log_strb[n_txn] = pstrb;
                  log_acc[n_txn]  = acc_cur;
               end
               n_txn++;
               acc_cur = 0;
            end
         end
      end
   end

   task automatic clear_log();
      n_txn = 0; setup_cnt = 0; acc_total = 0; acc_cur = 0;
      for (int i = 0; i < 16; i++) begin
         log_wr[i] = 1'bx; log_addr[i] = 'x; log_data[i] = 'x; log_strb[i] = 'x; log_acc[i] = -1;
      end
   endtask

   // Issue one command, wait for the response, hold rsp_ready low for 'hold' cycles.
   task automatic do_cmd(input logic [3:0] op, input logic [11:0] a, input logic [63:0] d,
                         input int hold, output logic [63:0] rd, output logic e);
      int n;
      rd = 'x; e = 1'bx;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
      checks++;
      if (!cmd_ready) begin
         errors++; $display("FAIL cmd_ready wait: got 0, want 1 within 50 cycles"); return;
      end
      clear_log();
      busy_low = 0; hold_bad = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
      @(negedge pclk);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 300) begin
         if (!busy) busy_low++;
         @(negedge pclk); n++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++; $display("FAIL rsp_valid wait: got 0, want 1 within 300 cycles"); return;
      end
      rd = rsp_rdata; e = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge pclk);
         if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e || !busy) hold_bad++;
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge pclk);
      checks++;
      if ({psel, penable, pwrite, cmd_ready, rsp_valid, busy, rsp_err} !== 7'b0) begin
         errors++; $display("FAIL reset ctrl: got %b, want 0000000", {psel, penable, pwrite, cmd_ready, rsp_valid, busy, rsp_err});
      end
      checks++;
      if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || rsp_rdata !== 64'h0) begin
         errors++; $display("FAIL reset data: got paddr=%h pwdata=%h pstrb=%h rdata=%h, want 0", paddr, pwdata, pstrb, rsp_rdata);
      end
      preset = 1'b0;
      @(negedge pclk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL ready after reset: got %b, want 1", cmd_ready);
      end
   endtask

   task automatic test_attach();
      logic [63:0] rd; logic e;
      logic [11:0] ea [0:2];
      ea = '{12'h000, 12'h004, 12'h008};
      do_cmd(OP_ATTACH, 12'h000, 64'h0, 0, rd, e);
      checks++;
      if (n_txn !== 3 || setup_cnt !== 3) begin
         errors++; $display("FAIL attach1 count: got txn=%0d setup=%0d, want 3 3", n_txn, setup_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (log_wr[i] !== 1'b1 || log_addr[i] !== 32'(ea[i]) || log_data[i] !== 32'h1 || log_strb[i] !== 4'hf || log_acc[i] !== 1) begin
            errors++; $display("FAIL attach1 txn%0d: got wr=%b addr=%h data=%h strb=%h acc=%0d, want 1 %h 00000001 f 1",
                               i, log_wr[i], log_addr[i], log_data[i], log_strb[i], log_acc[i], ea[i]);
         end
      end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL attach1 err: got %b, want 0", e); end
      do_cmd(OP_ATTACH, 12'h000, 64'h0, 0, rd, e);
      checks++;
      if (n_txn !== 2 || log_addr[0] !== 32'h004 || log_data[0] !== 32'h1 || log_addr[1] !== 32'h008) begin
         errors++; $display("FAIL attach2 seq: got txn=%0d a0=%h d0=%h a1=%h, want 2 004 00000001 008", n_txn, log_addr[0], log_data[0], log_addr[1]);
      end
   endtask

   task automatic test_gpr_rd();
      logic [63:0] rd; logic e;
      stall_addr = 12'h008; stall_n = 1;
      rd_l = 32'hDEADBEEF; rd_h = 32'hCAFEF00D;
      do_cmd(OP_GPR_RD, 12'h005, 64'h0, 0, rd, e);
      stall_n = 0; stall_addr = 12'hFFF;
      checks++;
      if (n_txn !== 4) begin errors++; $display("FAIL gpr_rd count: got %0d, want 4", n_txn); end
      checks++;
      if (log_addr[0] !== 32'h004 || log_data[0] !== 32'h00050007 || log_acc[0] !== 1) begin
         errors++; $display("FAIL gpr_rd inst: got addr=%h data=%h acc=%0d, want 004 00050007 1", log_addr[0], log_data[0], log_acc[0]);
      end
      checks++;
      if (log_addr[1] !== 32'h008 || log_acc[1] !== 2) begin
         errors++; $display("FAIL gpr_rd stretch: got addr=%h acc=%0d, want 008 2", log_addr[1], log_acc[1]);
      end
      checks++;
      if (log_wr[2] !== 1'b0 || log_addr[2] !== 32'h018 || log_strb[2] !== 4'h0 ||
          log_wr[3] !== 1'b0 || log_addr[3] !== 32'h01C || log_strb[3] !== 4'h0) begin
         errors++; $display("FAIL gpr_rd reads: got %b/%h/%h %b/%h/%h, want 0/018/0 0/01c/0",
                            log_wr[2], log_addr[2], log_strb[2], log_wr[3], log_addr[3], log_strb[3]);
      end
      checks++;
      if (rd !== 64'hCAFEF00D_DEADBEEF || e !== 1'b0) begin
         errors++; $display("FAIL gpr_rd data: got %h err=%b, want cafef00ddeadbeef 0", rd, e);
      end
   endtask

   task automatic test_csr_wr();
      logic [63:0] rd; logic e;
      logic [11:0] ea [0:4];
      logic [31:0] ed [0:4];
      ea = '{12'h00C, 12'h010, 12'h014, 12'h004, 12'h008};
      ed = '{32'h55667788, 32'h11223344, 32'h1, 32'h0300000A, 32'h1};
      do_cmd(OP_CSR_WR, 12'h300, 64'h11223344_55667788, 0, rd, e);
      checks++;
      if (n_txn !== 5) begin errors++; $display("FAIL csr_wr count: got %0d, want 5", n_txn); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (log_wr[i] !== 1'b1 || log_addr[i] !== 32'(ea[i]) || log_data[i] !== ed[i] || log_strb[i] !== 4'hf) begin
            errors++; $display("FAIL csr_wr txn%0d: got wr=%b addr=%h data=%h strb=%h, want 1 %h %h f",
                               i, log_wr[i], log_addr[i], log_data[i], log_strb[i], ea[i], ed[i]);
         end
      end
      checks++;
      if (rd !== 64'h0 || e !== 1'b0) begin errors++; $display("FAIL csr_wr rsp: got %h err=%b, want 0 0", rd, e); end
   endtask

   task automatic test_exec();
      logic [63:0] rd; logic e;
      logic [11:0] ea [0:5];
      logic [31:0] ed [0:5];
      ea = '{12'h00C, 12'h014, 12'h004, 12'h008, 12'h004, 12'h008};
      ed = '{32'h00100073, 32'h1, 32'h3, 32'h1, 32'h4, 32'h1};
      do_cmd(OP_EXEC, 12'h000, 64'h00100073, 3, rd, e);
      checks++;
      if (n_txn !== 6) begin errors++; $display("FAIL exec count: got %0d, want 6", n_txn); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (log_wr[i] !== 1'b1 || log_addr[i] !== 32'(ea[i]) || log_data[i] !== ed[i]) begin
            errors++; $display("FAIL exec txn%0d: got wr=%b addr=%h data=%h, want 1 %h %h",
                               i, log_wr[i], log_addr[i], log_data[i], ea[i], ed[i]);
         end
      end
      checks++;
      if (busy_low !== 0 || hold_bad !== 0) begin
         errors++; $display("FAIL exec hold: got busy_low=%0d hold_bad=%0d, want 0 0", busy_low, hold_bad);
      end
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rd !== 64'h0) begin
         errors++; $display("FAIL exec after: got valid=%b busy=%b ready=%b rd=%h, want 0 0 1 0", rsp_valid, busy, cmd_ready, rd);
      end
   endtask

   task automatic test_slverr();
      logic [63:0] rd; logic e;
      err_en = 1'b1; err_addr = 12'h004;
      do_cmd(OP_STATUS, 12'h000, 64'h0, 0, rd, e);
      err_en = 1'b0;
      checks++;
      if (n_txn !== 4 || log_addr[0] !== 32'h004 || log_data[0] !== 32'h5 || log_addr[3] !== 32'h01C) begin
         errors++; $display("FAIL slverr seq: got txn=%0d a0=%h d0=%h a3=%h, want 4 004 00000005 01c", n_txn, log_addr[0], log_data[0], log_addr[3]);
      end
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL slverr err: got %b, want 1", e); end
      rd_l = 32'h80000000; rd_h = 32'h00000001;
      do_cmd(OP_PC_RD, 12'h000, 64'h0, 0, rd, e);
      checks++;
      if (e !== 1'b0 || rd !== 64'h00000001_80000000 || log_data[0] !== 32'h6) begin
         errors++; $display("FAIL pc_rd after err: got err=%b rd=%h inst=%h, want 0 0000000180000000 00000006", e, rd, log_data[0]);
      end
   endtask

   task automatic test_illegal();
      logic [63:0] rd; logic e;
      do_cmd(4'd12, 12'h000, 64'h0, 0, rd, e);
      checks++;
      if (n_txn !== 0 || setup_cnt !== 0 || e !== 1'b1 || rd !== 64'h0) begin
         errors++; $display("FAIL illegal: got txn=%0d setup=%0d err=%b rd=%h, want 0 0 1 0", n_txn, setup_cnt, e, rd);
      end
   endtask

   task automatic test_reset_mid();
      int n, bad;
      stuck = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
      cmd_valid = 1'b1; cmd_op = OP_CSR_WR; cmd_addr = 12'h300; cmd_wdata = 64'h1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      n = 0;
      while (!(psel && penable) && n < 20) begin @(negedge pclk); n++; end
      checks++;
      if (!(psel && penable)) begin
         errors++; $display("FAIL reset_mid access: got psel=%b penable=%b, want 1 1", psel, penable);
      end
      #2 preset = 1'b1;
      #1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         errors++; $display("FAIL reset_mid async: got psel=%b penable=%b, want 0 0", psel, penable);
      end
      @(negedge pclk);
      stuck = 1'b0;
      preset = 1'b0;
      bad = 0;
      repeat (10) begin @(negedge pclk); if (rsp_valid || psel) bad++; end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL reset_mid lost: got %0d bad cycles, want 0", bad); end
   endtask

`ifdef DBGAPB_MST_TIMEOUT_EN
   task automatic test_timeout();
      logic [63:0] rd; logic e;
      stuck = 1'b1;
      do_cmd(OP_ATTACH, 12'h000, 64'h0, 0, rd, e);
      stuck = 1'b0;
      checks++;
      if (e !== 1'b1 || rd !== 64'h0 || n_txn !== 0 || acc_total !== 8 || setup_cnt !== 1) begin
         errors++; $display("FAIL timeout: got err=%b rd=%h txn=%0d acc=%0d setup=%0d, want 1 0 0 8 1", e, rd, n_txn, acc_total, setup_cnt);
      end
   endtask
`endif

   task automatic test_reissue();
      logic [63:0] rd; logic e;
      do_cmd(OP_ATTACH, 12'h000, 64'h0, 0, rd, e);
      checks++;
      if (n_txn !== 3 || log_addr[0] !== 32'h000 || log_data[0] !== 32'h1 || e !== 1'b0) begin
         errors++; $display("FAIL reissue: got txn=%0d a0=%h d0=%h err=%b, want 3 000 00000001 0", n_txn, log_addr[0], log_data[0], e);
      end
   endtask

   initial begin
      test_reset();
      test_attach();
      test_gpr_rd();
      test_csr_wr();
      test_exec();
      test_slverr();
      test_illegal();
      test_reset_mid();
`ifdef DBGAPB_MST_TIMEOUT_EN
      test_timeout();
`endif
      test_reissue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
